// File: rtl/bus_arbiter_rr8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr8_pkg
// Description : Shared constants, state encoding and helpers for the
//               eight-master round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_rr8_pkg;

    localparam int NUM_MASTERS = 8;
    localparam int SEL_W       = 3;

    // Default parameter values for the arbiter top level.
    localparam logic [SEL_W-1:0] C_PARK_ID_DEF  = 3'd0;
    localparam int               C_MAX_HOLD_DEF = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Binary master index to one-hot grant vector.
    function automatic logic [NUM_MASTERS-1:0] onehot8(input logic [SEL_W-1:0] idx);
        onehot8 = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr8_rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational round-robin search. Returns the first set
//               request bit found scanning upward from i_base, wrapping 7->0.
// Ports       : i_req  [7:0] candidate requests
//               i_base [2:0] index searched first
//               o_idx  [2:0] winning index (i_base when nothing requests)
//               o_any        at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import bus_arbiter_rr8_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [SEL_W-1:0]       i_base,
    output logic [SEL_W-1:0]       o_idx,
    output logic                   o_any
);

    logic [NUM_MASTERS-1:0] w_rot;

    always_comb begin
        // Rotate so that bit 0 of w_rot corresponds to master i_base.
        w_rot = NUM_MASTERS'({i_req, i_req} >> i_base);
        o_any = |i_req;
        o_idx = i_base;
        // Scan downward so the lowest rotated position (closest to the base)
        // is the last assignment and therefore wins.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_idx = i_base + SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_rr8.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr8
// Description : Eight-master round-robin bus arbiter. Drives the registered
//               select and one-hot grant of a downstream 32-bit 8:1 data mux.
// Ports       : clk          rising-edge clock
//               reset_n      asynchronous active-low reset
//               i_req  [7:0] level-sensitive bus requests, bit i = master i
//               i_done       last-beat strobe from the current owner
//               o_gnt  [7:0] registered one-hot grant, zero when idle
//               o_sel  [2:0] registered owner index, PARK_ID when idle
//               o_bus_valid  registered, high while a grant is active
//               o_timeout    one-cycle pulse on forced release
// Options     : `define ARB_TIMEOUT_EN enables the MAX_HOLD ownership limit;
//               without it o_timeout is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr8
    import bus_arbiter_rr8_pkg::*;
#(
    parameter logic [SEL_W-1:0] PARK_ID  = C_PARK_ID_DEF,
    parameter int               MAX_HOLD = C_MAX_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_done,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [SEL_W-1:0]       o_sel,
    output logic                   o_bus_valid,
    output logic                   o_timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $fatal(1, "bus_arbiter_rr8: MAX_HOLD must be within 2..255");
    end

    arb_state_t             r_state,  w_state_nxt;
    logic [NUM_MASTERS-1:0] r_gnt,    w_gnt_nxt;
    logic [SEL_W-1:0]       r_sel,    w_sel_nxt;
    logic                   r_valid,  w_valid_nxt;
    logic [SEL_W-1:0]       r_ptr,    w_ptr_nxt;
    logic                   r_to,     w_to_nxt;

    logic                   w_owner_req;
    logic                   w_release;
    logic                   w_to_hit;
    logic [NUM_MASTERS-1:0] w_pick_req;
    logic [SEL_W-1:0]       w_pick_base;
    logic [SEL_W-1:0]       w_pick_idx;
    logic                   w_pick_any;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold, w_hold_nxt;
    // Forced release only when the owner has not finished on its own.
    assign w_to_hit = (r_hold == 8'(MAX_HOLD - 1)) && !i_done;
`else
    assign w_to_hit = 1'b0;
`endif

    assign w_owner_req = i_req[r_sel];
    assign w_release   = (r_state == ARB_OWN) && (i_done || !w_owner_req || w_to_hit);

    // One picker serves both cases: idle arbitration from the stored pointer,
    // and release arbitration from owner+1 with the owner's own bit removed
    // so that it ends up with lowest priority.
    assign w_pick_req  = (r_state == ARB_OWN) ? (i_req & ~onehot8(r_sel)) : i_req;
    assign w_pick_base = (r_state == ARB_OWN) ? (r_sel + 3'd1) : r_ptr;

    rr_pick8 u_pick (
        .i_req  (w_pick_req),
        .i_base (w_pick_base),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        w_to_nxt    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_OWN;
                    w_gnt_nxt   = onehot8(w_pick_idx);
                    w_sel_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = 8'd0;
`endif
                end
            end
            ARB_OWN: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 3'd1;
                    w_to_nxt  = w_to_hit;
                    if (w_pick_any) begin
                        w_gnt_nxt = onehot8(w_pick_idx);
                        w_sel_nxt = w_pick_idx;
`ifdef ARB_TIMEOUT_EN
                        w_hold_nxt = 8'd0;
`endif
                    end else if (i_done && w_owner_req) begin
                        // Sole requester finished a transfer and wants more:
                        // keep the grant, treat it as a fresh ownership.
`ifdef ARB_TIMEOUT_EN
                        w_hold_nxt = 8'd0;
`endif
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_gnt_nxt   = '0;
                        w_sel_nxt   = PARK_ID;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt = r_hold + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
                w_sel_nxt   = PARK_ID;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_sel   <= PARK_ID;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_to    <= w_to_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`endif

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_bus_valid = r_valid;
    assign o_timeout   = r_to;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr8.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_rr8
// Description : Directed self-checking bench for bus_arbiter_rr8. Compares
//               {gnt, sel, bus_valid, timeout} against hand-computed vectors.
//               Timeout steps are compiled when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr8;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       bus_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_rr8 #(
        .PARK_ID  (3'd0),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (req),
        .i_done      (done),
        .o_gnt       (gnt),
        .o_sel       (sel),
        .o_bus_valid (bus_valid),
        .o_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ex(input logic [7:0] g, input logic [2:0] s,
                                       input logic v, input logic t);
        ex = {g, s, v, t};
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {gnt, sel, bus_valid, timeout};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed{gnt,sel,v,to}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs at a falling edge, let one rising edge pass, return at
    // the next falling edge where outputs are sampled.
    task automatic cyc(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'hFF;
        done    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", ex(8'h00, 3'd0, 1'b0, 1'b0));
        reset_n = 1'b1;
        #1;
        chk("reset_release_no_edge", ex(8'h00, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        chk("first_grant_after_reset", ex(8'h01, 3'd0, 1'b1, 1'b0));

        // Owner 0 aborts -> idle, pointer becomes 1.
        cyc(8'h00, 1'b0);
        chk("abort_to_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));

        // req 0x24 from pointer 1 -> master 2; done hands to 5 with no gap.
        cyc(8'h24, 1'b0);
        chk("grant_m2", ex(8'h04, 3'd2, 1'b1, 1'b0));
        cyc(8'h24, 1'b1);
        chk("done_switch_m5", ex(8'h20, 3'd5, 1'b1, 1'b0));
        cyc(8'h00, 1'b1);
        chk("done_no_req_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));

        // Pointer 6: grant 7, then wrap to 0, then back to 7.
        cyc(8'h80, 1'b0);
        chk("grant_m7", ex(8'h80, 3'd7, 1'b1, 1'b0));
        cyc(8'h81, 1'b1);
        chk("wrap_to_m0", ex(8'h01, 3'd0, 1'b1, 1'b0));
        cyc(8'h81, 1'b1);
        chk("back_to_m7", ex(8'h80, 3'd7, 1'b1, 1'b0));
        cyc(8'h00, 1'b0);
        chk("m7_abort_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));

        // Pointer 0: sole requester 3 re-granted on done without a gap.
        cyc(8'h08, 1'b0);
        chk("grant_m3", ex(8'h08, 3'd3, 1'b1, 1'b0));
        cyc(8'h08, 1'b1);
        chk("regrant_m3", ex(8'h08, 3'd3, 1'b1, 1'b0));
        cyc(8'h08, 1'b0);
        chk("m3_still_held", ex(8'h08, 3'd3, 1'b1, 1'b0));

        // Owner 3 drops, master 4 requests: direct switch.
        cyc(8'h10, 1'b0);
        chk("abort_switch_m4", ex(8'h10, 3'd4, 1'b1, 1'b0));
        cyc(8'h14, 1'b0);
        chk("other_req_ignored", ex(8'h10, 3'd4, 1'b1, 1'b0));
        cyc(8'h00, 1'b0);
        chk("m4_abort_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));

        // Pointer 5: only master 0 requests -> wrap search grants 0.
        cyc(8'h01, 1'b0);
        chk("grant_m0_from_ptr5", ex(8'h01, 3'd0, 1'b1, 1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_mid_own", ex(8'h00, 3'd0, 1'b0, 1'b0));
        req = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        chk("held_in_reset", ex(8'h00, 3'd0, 1'b0, 1'b0));
        // Pointer must be back at 0: 0x22 picks master 1, not 5.
        cyc(8'h22, 1'b0);
        chk("ptr_cleared_by_reset", ex(8'h02, 3'd1, 1'b1, 1'b0));
        cyc(8'h00, 1'b0);
        chk("m1_abort_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));
        cyc(8'h00, 1'b1);
        chk("done_while_idle", ex(8'h00, 3'd0, 1'b0, 1'b0));

        // Pointer 2: sole requester 1 holds without done.
        cyc(8'h02, 1'b0);
        chk("hold_grant_m1", ex(8'h02, 3'd1, 1'b1, 1'b0));
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 4; k++) begin
            cyc(8'h02, 1'b0);
            chk("hold_before_timeout", ex(8'h02, 3'd1, 1'b1, 1'b0));
        end
        cyc(8'h02, 1'b0);
        chk("timeout_release", ex(8'h00, 3'd0, 1'b0, 1'b1));
        cyc(8'h02, 1'b0);
        chk("regrant_after_timeout", ex(8'h02, 3'd1, 1'b1, 1'b0));
`else
        for (int k = 1; k < 8; k++) begin
            cyc(8'h02, 1'b0);
            chk("hold_indefinitely", ex(8'h02, 3'd1, 1'b1, 1'b0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
